// File: rtl/mux_2x1_4x1_pkg.sv
// Shared constants and select encoding for the registered 2:1 / 4:1 operand selector.
package mux_2x1_4x1_pkg;

    localparam int DEFAULT_WIDTH = 48;

    typedef enum logic [1:0] {
        SEL_IN0 = 2'd0,
        SEL_IN1 = 2'd1,
        SEL_IN2 = 2'd2,
        SEL_IN3 = 2'd3
    } sel4_e;

endpackage : mux_2x1_4x1_pkg

// File: rtl/mux_2x1_4x1_core_n.sv
// Purely combinational N-way selector; an undefined or out-of-range select yields all zeros.
module mux_core_n #(
    parameter int WIDTH = 48,
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [0:N-1][0:WIDTH-1] data,
    input  logic [0:SEL_W-1]        sel,
    output logic [0:WIDTH-1]        dout
);

    // An X/Z select never compares equal, so the zero default keeps X out of the datapath.
    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                dout = data[i];
            end
        end
    end

endmodule : mux_core_n

// File: rtl/mux_2x1_4x1.sv
// Registered 2:1 and 4:1 selectors over shared operands; one-cycle latency, sync active-low reset.
module mux_2x1_4x1
    import mux_2x1_4x1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] in0,
    input  logic [0:WIDTH-1] in1,
    input  logic [0:WIDTH-1] in2,
    input  logic [0:WIDTH-1] in3,
    input  logic             select_2x1,
    input  logic [0:1]       select_4x1,
    output logic [0:WIDTH-1] out2,
    output logic [0:WIDTH-1] out4
);

    logic [0:WIDTH-1] mux2_p0;
    logic [0:WIDTH-1] mux4_p0;

    // Stage p0: combinational selection on the operands presented this cycle
    mux_core_n #(
        .WIDTH (WIDTH),
        .N     (2),
        .SEL_W (1)
    ) u_mux2 (
        .data ({in0, in1}),
        .sel  (select_2x1),
        .dout (mux2_p0)
    );

    mux_core_n #(
        .WIDTH (WIDTH),
        .N     (4),
        .SEL_W (2)
    ) u_mux4 (
        .data ({in0, in1, in2, in3}),
        .sel  (select_4x1),
        .dout (mux4_p0)
    );

    // Stage p1: output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out2 <= '0;
            out4 <= '0;
        end else begin
            out2 <= mux2_p0;
            out4 <= mux4_p0;
        end
    end

endmodule : mux_2x1_4x1

// File: tb/tb_mux_2x1_4x1.sv
// Randomised and directed bench for mux_2x1_4x1 against a behavioural selector model.
module tb_mux_2x1_4x1;

    localparam int W = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:W-1]  in0, in1, in2, in3;
    logic          sel2;
    logic [0:1]    sel4;
    logic [0:W-1]  out2, out4;

    logic [0:W-1]  exp2, exp4;
    logic          exp_valid = 1'b0;

    int checks   = 0;
    int failures = 0;

    mux_2x1_4x1 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .select_2x1 (sel2),
        .select_4x1 (sel4),
        .out2       (out2),
        .out4       (out4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [0:W-1] act, input logic [0:W-1] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: what each register must hold after this edge.
    always @(posedge clk) begin
        logic [0:W-1] ops [4];
        ops[0] = in0;
        ops[1] = in1;
        ops[2] = in2;
        ops[3] = in3;
        if (rst_n === 1'b0) begin
            exp2 = '0;
            exp4 = '0;
        end else begin
            exp2 = ops[sel2 ? 1 : 0];
            exp4 = ops[int'(sel4)];
        end
        exp_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            check("model_out2", out2, exp2);
            check("model_out4", out4, exp4);
        end
    end

    initial begin
        rst_n = 1'b0;
        in0 = 48'hffffffffffff; in1 = '0; in2 = '0; in3 = '0;
        sel2 = 1'b0; sel4 = 2'd0;

        // Two reset edges
        @(negedge clk);
        @(negedge clk);
        check("reset_out2", out2, 48'h0);
        check("reset_out4", out4, 48'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_out2", out2, 48'hffffffffffff);
        check("release_out4", out4, 48'hffffffffffff);

        in0 = 48'hffffffffffff; in1 = 48'h0; in2 = 48'h555555555555; in3 = 48'haaaaaaaaaaaa;
        sel2 = 1'b0; sel4 = 2'd0;
        @(negedge clk);
        check("sweep2_sel0", out2, 48'hffffffffffff);
        check("sweep4_sel0", out4, 48'hffffffffffff);
        sel2 = 1'b1; sel4 = 2'd1;
        @(negedge clk);
        check("sweep2_sel1", out2, 48'h0);
        check("sweep4_sel1", out4, 48'h0);
        sel4 = 2'b10;
        @(negedge clk);
        check("indep_sel4_2", out2, 48'h0);
        check("sweep4_sel2", out4, 48'h555555555555);
        sel4 = 2'd3;
        @(negedge clk);
        check("indep_sel4_3", out2, 48'h0);
        check("sweep4_sel3", out4, 48'haaaaaaaaaaaa);

        // Mid-stream reset pulse
        sel4 = 2'd2;
        @(negedge clk);
        check("pre_rst_out4", out4, 48'h555555555555);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out4", out4, 48'h0);
        check("mid_rst_out2", out2, 48'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out4", out4, 48'h555555555555);

        // Bit order
        in1 = 48'h800000000001; sel2 = 1'b1;
        @(negedge clk);
        check("bitorder_out2", out2, 48'h800000000001);
        check("bitorder_msb", 48'(out2[0]), 48'h1);
        check("bitorder_lsb", 48'(out2[47]), 48'h1);

        // Randomised traffic, including occasional resets and simultaneous operand/select changes
        for (int n = 0; n < 400; n++) begin
            in0  = 48'({$urandom(), $urandom()});
            in1  = 48'({$urandom(), $urandom()});
            in2  = ($urandom_range(0, 7) == 0) ? 48'hffffffffffff : 48'({$urandom(), $urandom()});
            in3  = ($urandom_range(0, 7) == 0) ? 48'h0 : 48'({$urandom(), $urandom()});
            sel2 = 1'($urandom_range(0, 1));
            sel4 = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_2x1_4x1

// File: doc/mux_2x1_4x1.md
Name: mux_2x1_4x1

Overview:
- Registered datapath selector holding two independent multiplexers on a shared set of four WIDTH-bit operands.
  - A 2:1 mux over in0/in1 drives out2.
  - A 4:1 mux over in0..in3 drives out4.
- Used in the processor datapath to steer 48-bit operands/results.
- Both outputs are registered: one-cycle latency, synchronous active-low reset.

Parameters:
- WIDTH, 48, bit width of every data input and output; vectors declared [0:WIDTH-1].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in0  input  WIDTH  operand 0, shared by both muxes.
- in1  input  WIDTH  operand 1, shared by both muxes.
- in2  input  WIDTH  operand 2, 4:1 mux only.
- in3  input  WIDTH  operand 3, 4:1 mux only.
- select_2x1  input  1  2:1 select; 0 selects in0, 1 selects in1.
- select_4x1  input  2 ([0:1])  4:1 select, read as unsigned integer 0..3 selecting in0..in3.
- out2  output  WIDTH  registered 2:1 result.
- out4  output  WIDTH  registered 4:1 result.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, out2 and out4 load all zeros. Reset overrides any select or input activity in that cycle.
- Normal operation: on each rising clk edge with rst_n=1:
  - out2 <= (select_2x1 ? in1 : in0)
  - out4 <= in[select_4x1]
- Latency: exactly 1 cycle from input/select change to output. Outputs hold between edges and never glitch combinationally.
- Independence: the two muxes share operands but have independent selects. Changing one select never affects the other output.
- Full-width copy: the selected operand is passed bit-for-bit with no sign extension, truncation, or bit reversal. Bit 0 is the MSB in both input and output.
- Select decoding for select_4x1:
  - select_4x1[0] is the MSB, so value 2 is select_4x1=2'b10.
  - 0→in0, 1→in1, 2→in2, 3→in3.
- X/Z on a select input: the output register loads all zeros. This keeps X out of the datapath; it is a deterministic default branch.
- Reset mid-operation: the next edge with rst_n=0 clears both outputs regardless of the prior state. The first edge after rst_n returns high loads the normal mux result.
- Operand update on the same edge as a select change: the register captures the new select applied to the new operands, since both are sampled on the same edge.
- No handshake; each output is valid every cycle after reset is deasserted.

Decomposition:
- Shared package holds:
  - the default WIDTH constant (48);
  - a 2-bit select typedef with named constants SEL_IN0..SEL_IN3 = 0..3.
- One natural sub-module, mux_core_n:
  - a purely combinational N-way selector, parameterised by WIDTH and number of inputs;
  - instantiated twice (N=2 and N=4) ahead of the output registers.
- The top level adds only the reset/output flops.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in0=48'hffffffffffff and both selects 0 → out2=out4=48'h0. Release rst_n → next edge out2=out4=48'hffffffffffff.
- 2:1 sweep: in0=48'hffffffffffff, in1=48'h0. select_2x1=0 → out2=ffffffffffff one edge later; select_2x1=1 → out2=000000000000 one edge later.
- 4:1 sweep: in0=ffffffffffff, in1=0, in2=555555555555, in3=aaaaaaaaaaaa. select_4x1=0,1,2,3 on consecutive cycles → out4=ffffffffffff, 000000000000, 555555555555, aaaaaaaaaaaa, each one cycle after its select.
- Independence: hold select_2x1=1 while sweeping select_4x1 0..3 → out2 stays 000000000000 throughout.
- Mid-stream reset: with select_4x1=2 and out4=555555555555, pulse rst_n=0 for one edge → out4=0 at that edge, then 555555555555 at the following edge.
- Bit order: in1=48'h800000000001, select_2x1=1 → out2=800000000001, with out2[0]=1 and out2[47]=1.
